// File: rtl/dispense_payout_ctrl.sv
// dispense_payout_ctrl: drives the product motor and coin ejector after a vend,
// keeps per-item stock and pays change/refunds as 10- and 5-rupee coins.
module dispense_payout_ctrl #(
    parameter int MOTOR_CYCLES = 8,
    parameter int STOCK_MAX    = 31,
    parameter int INIT_STOCK   = 0,
    parameter int WATER_COST   = 15,
    parameter int SODA_COST    = 20,
    parameter int LEMON_COST   = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] product,
    input  logic       give,
    input  logic [4:0] change,
    input  logic       restock_en,
    input  logic [1:0] restock_sel,
    input  logic [4:0] restock_qty,
    input  logic       coin_ack,
    output logic       motor_en,
    output logic [1:0] motor_sel,
    output logic       coin10_eject,
    output logic       coin5_eject,
    output logic [4:0] water_avail,
    output logic [4:0] soda_avail,
    output logic [4:0] lemon_avail,
    output logic       busy,
    output logic       done,
    output logic       stock_fault,
    output logic       req_dropped,
    output logic       payout_err
);
    localparam int CW = MOTOR_CYCLES > 1 ? $clog2(MOTOR_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, MOTOR, PAY, WAIT_ACK, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      prod_q, item_q, item_nxt;
    logic            give_q;
    logic [5:0]      remaining, rem_nxt, cost;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [4:0]      stock [1:3];
    logic [4:0]      stock_nxt [1:3];
    logic [4:0]      sel_stock;
    logic            vend_req, refund_req, dec_ok, fault_set, err_set, drop_set;

    function automatic logic [4:0] upd(input logic [4:0] s, input logic dec, input logic [4:0] add);
        logic [6:0] t;
        t = {2'b0, s} + {2'b0, add} - {6'b0, dec};
        return t > 7'(STOCK_MAX) ? 5'(STOCK_MAX) : t[4:0];
    endfunction

    assign vend_req   = product != 2'd0 && prod_q == 2'd0;
    assign refund_req = give && !give_q;
    assign sel_stock  = product == 2'd1 ? stock[1] : product == 2'd2 ? stock[2] : stock[3];
    assign cost       = product == 2'd1 ? 6'(WATER_COST) : product == 2'd2 ? 6'(SODA_COST) : 6'(LEMON_COST);
    assign dec_ok     = state == IDLE && vend_req && sel_stock != 5'd0;

    for (genvar i = 1; i <= 3; i++) begin : g_stock
        assign stock_nxt[i] = upd(stock[i], dec_ok && product == 2'(i),
                                  restock_en && restock_sel == 2'(i) ? restock_qty : 5'd0);
        always_ff @(posedge clk or posedge reset)
            if (reset) stock[i] <= 5'(INIT_STOCK);
            else       stock[i] <= stock_nxt[i];
    end

    assign water_avail  = stock[1];
    assign soda_avail   = stock[2];
    assign lemon_avail  = stock[3];
    assign motor_en     = state == MOTOR;
    assign motor_sel    = motor_en ? item_q : 2'd0;
    assign coin10_eject = state == PAY && remaining >= 6'd10;
    assign coin5_eject  = state == PAY && remaining < 6'd10 && remaining >= 6'd5;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        cnt_nxt   = cnt;
        item_nxt  = item_q;
        fault_set = 1'b0;
        err_set   = 1'b0;
        drop_set  = state != IDLE && (vend_req || refund_req);
        case (state)
            IDLE: begin
                if (vend_req) begin
                    item_nxt = product;
                    if (sel_stock != 5'd0) begin
                        state_nxt = MOTOR;
                        cnt_nxt   = CW'(MOTOR_CYCLES - 1);
                        rem_nxt   = {1'b0, change};
                    end else begin
                        // empty item: refund its price along with the change
                        fault_set = 1'b1;
                        rem_nxt   = {1'b0, change} + cost;
                        state_nxt = PAY;
                    end
                end else if (refund_req) begin
                    rem_nxt   = {1'b0, change};
                    state_nxt = PAY;
                end
            end
            MOTOR: begin
                if (cnt == '0) state_nxt = PAY;
                else           cnt_nxt   = cnt - 1'b1;
            end
            PAY: begin
                if (remaining >= 6'd10) begin
                    rem_nxt   = remaining - 6'd10;
                    state_nxt = WAIT_ACK;
                end else if (remaining >= 6'd5) begin
                    rem_nxt   = remaining - 6'd5;
                    state_nxt = WAIT_ACK;
                end else begin
                    err_set   = remaining != 6'd0;
                    rem_nxt   = 6'd0;
                    state_nxt = DONE;
                end
            end
            WAIT_ACK: if (coin_ack) state_nxt = PAY;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prod_q      <= 2'd0;
            give_q      <= 1'b0;
            remaining   <= 6'd0;
            cnt         <= '0;
            item_q      <= 2'd0;
            stock_fault <= 1'b0;
            req_dropped <= 1'b0;
            payout_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            prod_q      <= product;
            give_q      <= give;
            remaining   <= rem_nxt;
            cnt         <= cnt_nxt;
            item_q      <= item_nxt;
            stock_fault <= fault_set;
            req_dropped <= req_dropped | drop_set;
            payout_err  <= payout_err | err_set;
        end
    end
endmodule

// File: tb/tb_dispense_payout_ctrl.sv
// tb_dispense_payout_ctrl: vector table plus hand sequences; coin/done events
// are checked against a queue of expected events filled when a request is driven.
module tb_dispense_payout_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic [1:0] product = 2'd0, restock_sel = 2'd0;
    logic       give = 1'b0, restock_en = 1'b0, coin_ack = 1'b0;
    logic [4:0] change = 5'd0, restock_qty = 5'd0;
    logic       motor_en, coin10_eject, coin5_eject, busy, done, stock_fault, req_dropped, payout_err;
    logic [1:0] motor_sel;
    logic [4:0] water_avail, soda_avail, lemon_avail;

    always #5 clk = ~clk;

    dispense_payout_ctrl dut (
        .clk(clk), .reset(reset), .product(product), .give(give), .change(change),
        .restock_en(restock_en), .restock_sel(restock_sel), .restock_qty(restock_qty),
        .coin_ack(coin_ack), .motor_en(motor_en), .motor_sel(motor_sel),
        .coin10_eject(coin10_eject), .coin5_eject(coin5_eject),
        .water_avail(water_avail), .soda_avail(soda_avail), .lemon_avail(lemon_avail),
        .busy(busy), .done(done), .stock_fault(stock_fault),
        .req_dropped(req_dropped), .payout_err(payout_err)
    );

    typedef struct {
        logic [1:0] rs_sel;
        logic [4:0] rs_qty;
        logic [4:0] exp_rs;
        logic [1:0] prod;
        logic       gv;
        logic [4:0] chg;
        int         exp_motor;
        int         exp_fault;
        int         n10;
        int         n5;
        logic [1:0] chk_sel;
        logic [4:0] exp_stock;
        logic       exp_err;
    } vec_t;

    vec_t       vecs [8];
    int         total = 0, bad = 0;
    int         exp_q [$];
    int         motor_cnt = 0, fault_cnt = 0, ack_wait = 0;
    logic       done_seen = 1'b0;
    logic [1:0] exp_sel = 2'd0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sb(input int code);
        if (exp_q.size() == 0) chk("sb_unexpected_event", code, -1);
        else chk("sb_event", code, exp_q.pop_front());
    endtask

    function automatic logic [4:0] avail(input logic [1:0] s);
        return s == 2'd1 ? water_avail : s == 2'd2 ? soda_avail : lemon_avail;
    endfunction

    // one cycle: observe outputs on the falling edge, then act as the coin ejector
    task automatic step();
        @(negedge clk);
        if (motor_en) motor_cnt++;
        if (stock_fault) fault_cnt++;
        chk("motor_sel", motor_sel, motor_en ? exp_sel : 2'd0);
        chk("eject_overlap", coin10_eject & coin5_eject, 0);
        if (coin10_eject) sb(10);
        if (coin5_eject) sb(5);
        if (done) begin
            sb(0);
            done_seen = 1'b1;
        end
        coin_ack = 1'b0;
        if (coin10_eject || coin5_eject) ack_wait = 2;
        else if (ack_wait > 0) begin
            ack_wait--;
            coin_ack = ack_wait == 0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 300) begin
            step();
            n++;
        end
        chk("done_timeout", done_seen, 1);
    endtask

    task automatic push(input int n10, input int n5);
        repeat (n10) exp_q.push_back(10);
        repeat (n5) exp_q.push_back(5);
        exp_q.push_back(0);
    endtask

    task automatic restock(input logic [1:0] sel, input logic [4:0] qty);
        restock_en = 1'b1; restock_sel = sel; restock_qty = qty;
        step();
        restock_en = 1'b0; restock_sel = 2'd0; restock_qty = 5'd0;
    endtask

    task automatic start(input logic [1:0] sel);
        motor_cnt = 0; fault_cnt = 0; done_seen = 1'b0; exp_sel = sel;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          rs  qty ers prod gv chg mot flt n10 n5 sel stk err
        vecs[0] = '{2'd1, 5'd3, 5'd3, 2'd1, 1'b0, 5'd5,  8, 0, 0, 1, 2'd1, 5'd2, 1'b0};
        vecs[1] = '{2'd3, 5'd1, 5'd1, 2'd3, 1'b0, 5'd15, 8, 0, 1, 1, 2'd3, 5'd0, 1'b0};
        vecs[2] = '{2'd0, 5'd0, 5'd0, 2'd2, 1'b0, 5'd0,  0, 1, 2, 0, 2'd2, 5'd0, 1'b0};
        vecs[3] = '{2'd0, 5'd0, 5'd0, 2'd0, 1'b1, 5'd25, 0, 0, 2, 1, 2'd1, 5'd2, 1'b0};
        vecs[4] = '{2'd2, 5'd2, 5'd2, 2'd2, 1'b0, 5'd0,  8, 0, 0, 0, 2'd2, 5'd1, 1'b0};
        vecs[5] = '{2'd0, 5'd0, 5'd0, 2'd1, 1'b0, 5'd3,  8, 0, 0, 0, 2'd1, 5'd1, 1'b1};
        vecs[6] = '{2'd0, 5'd0, 5'd0, 2'd3, 1'b0, 5'd31, 0, 1, 5, 1, 2'd3, 5'd0, 1'b1};
        vecs[7] = '{2'd0, 5'd0, 5'd0, 2'd2, 1'b1, 5'd5,  8, 0, 0, 1, 2'd2, 5'd0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_motor", {motor_en, motor_sel}, 0);
        chk("rst_eject", {coin10_eject, coin5_eject}, 0);
        chk("rst_flags", {done, stock_fault, req_dropped, payout_err}, 0);
        chk("rst_water", water_avail, 0);
        chk("rst_soda", soda_avail, 0);
        chk("rst_lemon", lemon_avail, 0);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].rs_sel != 2'd0) begin
                restock(vecs[k].rs_sel, vecs[k].rs_qty);
                chk("restock_avail", avail(vecs[k].rs_sel), vecs[k].exp_rs);
            end
            start(vecs[k].prod);
            push(vecs[k].n10, vecs[k].n5);
            product = vecs[k].prod; give = vecs[k].gv; change = vecs[k].chg;
            step();
            product = 2'd0; give = 1'b0; change = 5'd0;
            chk("motor_start", motor_en, vecs[k].exp_motor > 0);
            chk("busy_after_req", busy, 1);
            wait_done();
            step();
            chk("motor_cycles", motor_cnt, vecs[k].exp_motor);
            chk("stock_fault_pulses", fault_cnt, vecs[k].exp_fault);
            chk("stock_after", avail(vecs[k].chk_sel), vecs[k].exp_stock);
            chk("payout_err", payout_err, vecs[k].exp_err);
            chk("queue_empty", exp_q.size(), 0);
            chk("idle_after", busy, 0);
        end

        // saturation and same-cycle restock+vend
        restock(2'd1, 5'd29);
        chk("water_30", water_avail, 30);
        restock(2'd1, 5'd5);
        chk("water_sat_31", water_avail, 31);
        start(2'd1);
        push(0, 0);
        restock_en = 1'b1; restock_sel = 2'd1; restock_qty = 5'd3; product = 2'd1;
        step();
        restock_en = 1'b0; restock_sel = 2'd0; restock_qty = 5'd0; product = 2'd0;
        chk("concurrent_sat", water_avail, 31);
        wait_done();
        step();
        chk("concurrent_motor", motor_cnt, 8);
        restock(2'd2, 5'd3);
        chk("soda_3", soda_avail, 3);
        start(2'd2);
        push(0, 0);
        restock_en = 1'b1; restock_sel = 2'd2; restock_qty = 5'd2; product = 2'd2;
        step();
        restock_en = 1'b0; restock_sel = 2'd0; restock_qty = 5'd0; product = 2'd0;
        chk("concurrent_sum", soda_avail, 4);
        wait_done();
        step();

        // vend request while waiting for a coin ack is dropped
        chk("drop_before", req_dropped, 0);
        start(2'd0);
        push(1, 0);
        give = 1'b1; change = 5'd10;
        step();
        give = 1'b0; change = 5'd0;
        step();
        product = 2'd1;
        step();
        product = 2'd0;
        chk("req_dropped", req_dropped, 1);
        wait_done();
        step();
        chk("drop_no_motor", motor_cnt, 0);
        chk("drop_water", water_avail, 31);
        chk("drop_queue", exp_q.size(), 0);

        // ack outside WAIT_ACK is ignored
        coin_ack = 1'b1;
        step();
        chk("ack_idle_busy", busy, 0);

        // reset in the middle of a motor run
        restock(2'd3, 5'd2);
        chk("lemon_2", lemon_avail, 2);
        start(2'd3);
        product = 2'd3;
        step();
        product = 2'd0;
        step();
        step();
        chk("mid_motor", motor_en, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_motor", motor_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_lemon", lemon_avail, 0);
        chk("rst_mid_water", water_avail, 0);
        chk("rst_mid_sticky", {req_dropped, payout_err}, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        ack_wait = 0;
        repeat (12) step();
        chk("rst_no_done", done_seen, 0);
        chk("rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
